// File: rtl/qpsk_bit_splitter_if.sv
// Serial bit input and held dibit output bundle of the QPSK bit splitter.
// master drives the bitstream and watches the levels; slave is the splitter.
interface qpsk_bit_splitter_if;
    logic din;
    logic din_valid;
    logic din_ready;
    logic e;
    logic o;
    logic sym_strobe;
    logic underrun;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  e,
        input  o,
        input  sym_strobe,
        input  underrun
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output e,
        output o,
        output sym_strobe,
        output underrun
    );
endinterface

// File: rtl/qpsk_bit_splitter.sv
// Groups a serial bitstream into dibits and presents them as E/O levels held for SYM_LEN clocks.
// Latency 1..SYM_LEN clocks; din_ready drops while a pair waits; optional OQPSK_OFFSET_EN delays O by half a symbol.
module qpsk_bit_splitter #(
    parameter int SYM_LEN   = 100,
    parameter bit BIT_ORDER = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    qpsk_bit_splitter_if.slave bus
);

    localparam int            CW   = $clog2(SYM_LEN);
    localparam logic [CW-1:0] LAST = CW'(SYM_LEN - 1);
`ifdef OQPSK_OFFSET_EN
    localparam logic [CW-1:0] MID  = CW'(SYM_LEN / 2 - 1);
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          bit_a;
    logic          bit_b;
    logic          boundary;
    logic          xfer;
    logic          even_bit;
    logic          odd_bit;
`ifdef OQPSK_OFFSET_EN
    logic          o_shadow;
`endif

    assign boundary      = (cnt == LAST);
    assign bus.din_ready = (state != FULL);
    assign xfer          = bus.din_valid && bus.din_ready;
    assign even_bit      = BIT_ORDER ? bit_b : bit_a;
    assign odd_bit       = BIT_ORDER ? bit_a : bit_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt            <= '0;
            state          <= EMPTY;
            bit_a          <= 1'b0;
            bit_b          <= 1'b0;
            bus.e          <= 1'b0;
            bus.o          <= 1'b0;
            bus.sym_strobe <= 1'b0;
            bus.underrun   <= 1'b0;
`ifdef OQPSK_OFFSET_EN
            o_shadow       <= 1'b0;
`endif
        end else begin
            cnt            <= boundary ? '0 : cnt + 1'b1;
            bus.sym_strobe <= 1'b0;
            bus.underrun   <= 1'b0;

            // ready is low while FULL, so no transfer can collide with the load
            if (boundary && state == FULL) begin
                bus.e          <= even_bit;
`ifdef OQPSK_OFFSET_EN
                o_shadow       <= odd_bit;
`else
                bus.o          <= odd_bit;
`endif
                state          <= EMPTY;
                bus.sym_strobe <= 1'b1;
            end else begin
                if (boundary) begin
                    bus.underrun <= 1'b1;
                end
                if (xfer) begin
                    case (state)
                        EMPTY: begin
                            bit_a <= bus.din;
                            state <= HALF;
                        end
                        HALF: begin
                            bit_b <= bus.din;
                            state <= FULL;
                        end
                        default: begin
                        end
                    endcase
                end
            end

`ifdef OQPSK_OFFSET_EN
            // shadow is untouched on underrun, so O simply reloads its old value
            if (cnt == MID) begin
                bus.o <= o_shadow;
            end
`endif
        end
    end

endmodule

// File: doc/qpsk_bit_splitter.md
Name: qpsk_bit_splitter

Overview:
Upstream stage of the QPSK modulator. Accepts a serial data bitstream over a valid/ready handshake and groups bits into dibits. Presents the dibit as held E (even) and O (odd) levels that change only on symbol boundaries every SYM_LEN clocks, matching the modulator's one-carrier-period-per-symbol sine table. Flags underrun when no complete dibit is available at a boundary.

Parameters:
SYM_LEN, 100, clocks per symbol; must equal the modulator sine table period; legal range 4..4095.
BIT_ORDER, 0, 0: first received bit of the pair goes to E, second to O; 1: reversed.

Ports:
Clk  input  1  system clock; all logic on the rising edge.
Rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of Clk.
Din  input  1  serial data bit.
Din_valid  input  1  Din is valid this cycle.
Din_ready  output  1  block can accept a bit this cycle; a transfer occurs when Din_valid and Din_ready are both 1.
E  output  1  even-bit level to the modulator, held for a full symbol.
O  output  1  odd-bit level to the modulator, held for a full symbol.
Sym_strobe  output  1  one-cycle pulse coincident with the first cycle of each new E/O value.
Underrun  output  1  one-cycle pulse: a boundary passed without a complete dibit.

Behaviour:
- Reset (Rst_n=0 at an edge):
  - E=0, O=0, Sym_strobe=0, Underrun=0.
  - Symbol counter=0, pair buffer EMPTY, Din_ready=1 on the following cycle.
  - Reset mid-symbol discards any partial or complete pair.
- Symbol counter:
  - Width ceil(log2(SYM_LEN)). Free-running after reset: 0..SYM_LEN-1, then wraps to 0.
  - The boundary is the edge on which the counter equals SYM_LEN-1.
- Pair buffer FSM has three states: EMPTY, HALF (one bit held), FULL (two bits held).
  - EMPTY + transfer -> HALF; stores bit A.
  - HALF + transfer -> FULL; stores bit B.
  - Din_ready = (state != FULL), combinational from state only.
- At a boundary with state FULL:
  - E/O load from A/B per BIT_ORDER.
  - State -> EMPTY; Sym_strobe=1 for the next cycle, aligned with the new E/O.
  - No transfer can coincide, because ready=0 while FULL.
- At a boundary with state EMPTY or HALF:
  - E/O hold their previous values and Sym_strobe stays 0.
  - Underrun=1 for one cycle.
  - A HALF bit is retained. A transfer on that same edge is still accepted (EMPTY->HALF or HALF->FULL); that pair loads at the next boundary.
- Latency: a pair completed at counter value k appears on E/O at counter 0 of the next symbol. Worst case SYM_LEN cycles, minimum 1 cycle (completed at k=SYM_LEN-2).
- E and O are registered outputs with no combinational path from Din.
- Steady state: sustained throughput is 2 bits per SYM_LEN clocks; upstream is back-pressured via Din_ready.

Optional Feature:
Macro OQPSK_OFFSET_EN.
- Defined: O lags E by half a symbol for offset-QPSK.
  - At the boundary, E loads as above and the O-bit goes to a shadow register.
  - O loads from the shadow register on the edge where the counter equals (SYM_LEN/2)-1, integer division.
  - Sym_strobe marks the E update only.
  - On underrun the shadow register is not updated and O holds.
- Not defined: E and O update on the same edge; no shadow register is present.

Test Plan:
- Reset: hold Rst_n=0 for 3 cycles with Din_valid=1 -> E=0, O=0, Sym_strobe=0, Underrun=0, counter 0; Din_ready=1 on the first cycle after release.
- Basic load: SYM_LEN=100, BIT_ORDER=0; send bits 1 then 0 at counter 5 and 6 -> at counter 0 of the next symbol E=1, O=0, Sym_strobe=1 for exactly one cycle. Both hold for 100 cycles.
- Back-pressure: Din_valid stuck at 1 with pattern 1,1,0,1,0,0 -> Din_ready goes low after each 2nd bit. E/O sequence: (1,1), (0,1), (0,0) on consecutive boundaries, with no Underrun.
- Underrun: send one bit (1) then stall past the boundary -> E/O unchanged, Underrun pulses once. Then send 0 -> next boundary loads E=1, O=0.
- Reset mid-operation: state FULL at counter 50, assert Rst_n=0 for 1 cycle -> pair discarded, E=O=0, counter restarts at 0, Din_ready=1.
- OQPSK_OFFSET_EN defined, SYM_LEN=100: pair (1,1) after (0,0) -> E rises at counter 0, O rises at counter 50, Sym_strobe only at counter 0.
